in_debounce: RTL

Per-bit debouncer and event latch placed directly downstream of the input-conditioning stage. It consumes already-resynchronised level inputs and qualifies each bit against a prescaled sample tick. It outputs clean debounced levels, single-cycle rise/fall pulses, and sticky per-bit event flags that software or a control FSM clears. Typical uses are front-panel switches and encoder pins ahead of the register/interrupt logic.

---
 rtl/in_debounce_if.sv | 35 +++
 rtl/in_debounce.sv | 108 ++++++++++
 2 files changed

// File: rtl/in_debounce_if.sv
// in_debounce bus bundle: conditioned inputs and clears in,
// debounced levels, edge pulses and sticky events out.
interface in_debounce_if #(
  parameter int DATA_W = 8
) ();

  logic [DATA_W-1:0] data_i;
  logic [DATA_W-1:0] clr_i;
  logic [DATA_W-1:0] data_o;
  logic [DATA_W-1:0] rise_o;
  logic [DATA_W-1:0] fall_o;
  logic [DATA_W-1:0] evt_o;
  logic              any_evt_o;

  modport master (
    output data_i,
    output clr_i,
    input  data_o,
    input  rise_o,
    input  fall_o,
    input  evt_o,
    input  any_evt_o
  );

  modport slave (
    input  data_i,
    input  clr_i,
    output data_o,
    output rise_o,
    output fall_o,
    output evt_o,
    output any_evt_o
  );

endinterface

// File: rtl/in_debounce.sv
// Per-bit debouncer with prescaled sample tick, registered
// rise/fall pulses and software-clearable sticky event flags.
module in_debounce #(
  parameter int                 DATA_W       = 8,
  parameter int                 TICK_DIV     = 1000,
  parameter int                 STABLE_TICKS = 4,
  parameter logic [DATA_W-1:0]  RST_VAL      = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  in_debounce_if.slave bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_TICKS + 1);

  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_TICKS - 1);

  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] clr;

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;
  logic          tick;

  logic [DATA_W-1:0][CW-1:0] cnt_q;
  logic [DATA_W-1:0][CW-1:0] cnt_d;

  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;
  logic [DATA_W-1:0] rise_q;
  logic [DATA_W-1:0] rise_d;
  logic [DATA_W-1:0] fall_q;
  logic [DATA_W-1:0] fall_d;
  logic [DATA_W-1:0] evt_q;
  logic [DATA_W-1:0] evt_d;
  logic              any_q;
  logic              any_d;

  assign din = bus.data_i;
  assign clr = bus.clr_i;

  // Prescaler: free-running 0..TICK_DIV-1, tick on the last count.
  always_comb begin
    tick  = (pre_q == PMAX);
    pre_d = pre_q + PW'(1);
    if (tick) begin
      pre_d = '0;
    end
  end

  // Qualify each bit: any match clears its count, ticks advance it.
  always_comb begin
    cnt_d  = cnt_q;
    data_d = data_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (din[i] == data_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick) begin
        if (cnt_q[i] == CMAX) begin
          data_d[i] = din[i];
          cnt_d[i]  = '0;
          rise_d[i] = din[i];
          fall_d[i] = ~din[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Sticky events: a new edge outranks a same-cycle clear.
  always_comb begin
    evt_d = (evt_q & ~clr) | rise_d | fall_d;
    any_d = |evt_q;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pre_q  <= '0;
      cnt_q  <= '0;
      data_q <= RST_VAL;
      rise_q <= '0;
      fall_q <= '0;
      evt_q  <= '0;
      any_q  <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      evt_q  <= evt_d;
      any_q  <= any_d;
    end
  end

  assign bus.data_o    = data_q;
  assign bus.rise_o    = rise_q;
  assign bus.fall_o    = fall_q;
  assign bus.evt_o     = evt_q;
  assign bus.any_evt_o = any_q;

endmodule
